// File: rtl/ddr3_arb_pkg.sv
// Command field layout and address-mapping helpers shared by the DDR3 command
// arbiter and the controller's bank/row decode.
package ddr3_arb_pkg;
  localparam int CMD_W      = 65;
  localparam int CMD_WR_BIT = 64;
  localparam int ADDR_LSB   = 32;
  localparam int BANK_LSB   = 10;
  localparam int BANK_W     = 3;
  localparam int ROW_LSB    = 13;
  localparam int ROW_W      = 16;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } ddr3_cmd_t;

  function automatic logic [BANK_W-1:0] bank_of(input logic [31:0] addr);
    return addr[BANK_LSB +: BANK_W];
  endfunction

  function automatic logic [ROW_W-1:0] row_of(input logic [31:0] addr);
    return addr[ROW_LSB +: ROW_W];
  endfunction
endpackage

// File: rtl/ddr3_cmd_fifo.sv
// Synchronous DEPTH-entry command queue; the head reads as zero while empty.
module ddr3_cmd_fifo #(
  parameter int W     = 67,
  parameter int DEPTH = 4
) (
  input  logic                   ck,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != (AW+1)'(DEPTH)) || do_pop);

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge ck) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = (count == '0) ? '0 : mem[rd_ptr];
endmodule

// File: rtl/ddr3_cmd_arbiter.sv
// Round-robin arbiter feeding a command queue for the shared DDR3 command port.
// Optional open-row preference is built when DDR3_ARB_ROW_HIT_EN is defined.
module ddr3_cmd_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                        ck,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ-1:0][CMD_W-1:0]  req_data,
  output logic [NREQ-1:0]             req_ready,
  output logic                        cmd_ready,
  output logic [CMD_W-1:0]            cmd_data,
  output logic [$clog2(NREQ)-1:0]     cmd_src,
  input  logic                        cmd_get,
  output logic [$clog2(DEPTH):0]      fifo_level
);
  localparam int SRC_W = $clog2(NREQ);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  if (NREQ < 2 || NREQ > 8 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_WAIT < 1) begin : g_param_check
    $error("ddr3_cmd_arbiter: illegal NREQ/DEPTH/MAX_WAIT");
  end

  logic                   get_d;
  logic                   pop_pend;
  logic                   pop;
  logic                   push;
  logic                   space;
  logic                   rr_adv;
  logic [SRC_W-1:0]       rr_ptr;
  logic [SRC_W-1:0]       gnt_idx;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        cand;
  logic [CMD_W+SRC_W-1:0] head;
  logic [LVL_W-1:0]       count;

  assign pop   = pop_pend && (count != '0);
  assign space = (count != LVL_W'(DEPTH)) || pop;

`ifdef DDR3_ARB_ROW_HIT_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  ddr3_cmd_t                     head_cmd;
  logic [BANK_W-1:0]             open_bank;
  logic [ROW_W-1:0]              open_row;
  logic                          open_vld;
  logic [NREQ-1:0]               hit;
  logic [NREQ-1:0]               at_max;
  logic [NREQ-1:0][WAIT_W-1:0]   wait_cnt;
  logic                          starve;
  logic                          hit_sel;

  assign head_cmd = ddr3_cmd_t'(head[CMD_W-1:0]);

  always_comb begin
    hit    = '0;
    at_max = '0;
    for (int i = 0; i < NREQ; i++) begin
      hit[i]    = open_vld &&
                  (bank_of(req_data[i][ADDR_LSB +: 32]) == open_bank) &&
                  (row_of(req_data[i][ADDR_LSB +: 32]) == open_row);
      at_max[i] = (wait_cnt[i] == WAIT_W'(MAX_WAIT));
    end
  end

  // A starving requester suspends the row-hit shortcut until it is served.
  assign starve  = |at_max;
  assign hit_sel = !starve && |(req_valid & hit);
  assign cand    = hit_sel ? (req_valid & hit) : req_valid;
  assign rr_adv  = push && !hit_sel;

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      open_vld <= 1'b0;
      wait_cnt <= '0;
    end else begin
      if (pop) open_vld <= 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i])
          wait_cnt[i] <= '0;
        else if (req_valid[i] && !at_max[i])
          wait_cnt[i] <= wait_cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge ck) begin
    if (pop) begin
      open_bank <= bank_of(head_cmd.addr);
      open_row  <= row_of(head_cmd.addr);
    end
  end
`else
  assign cand   = req_valid;
  assign rr_adv = push;
`endif

  always_comb begin
    int   j;
    logic found;
    j       = 0;
    found   = 1'b0;
    gnt     = '0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && cand[j]) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = SRC_W'(j);
      end
    end
    if (rst || !space) gnt = '0;
  end

  assign push      = |(req_valid & gnt);
  assign req_ready = gnt;

  // Fetch edge detect: the pop lands one edge after cmd_get is first seen high.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      get_d    <= 1'b0;
      pop_pend <= 1'b0;
      rr_ptr   <= '0;
    end else begin
      get_d <= cmd_get;
      if (pop_pend)
        pop_pend <= 1'b0;
      else if (cmd_get && !get_d && (count != '0))
        pop_pend <= 1'b1;
      if (rr_adv)
        rr_ptr <= (gnt_idx == SRC_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  ddr3_cmd_fifo #(
    .W     (CMD_W + SRC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .ck        (ck),
    .rst       (rst),
    .push      (push),
    .push_data ({gnt_idx, req_data[gnt_idx]}),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign cmd_ready  = (count != '0);
  assign cmd_data   = head[CMD_W-1:0];
  assign cmd_src    = head[CMD_W +: SRC_W];
  assign fifo_level = count;
endmodule

// File: doc/ddr3_cmd_arbiter.md
# ddr3_cmd_arbiter

Round-robin arbiter and command queue that shares the single DDR3 controller command port among `NREQ` AHB-side requesters. Each requester presents 65-bit commands on a valid/ready handshake: write flag in [64], address in [63:32], write data in [31:0]. The block queues granted commands and presents the queue head to the controller on the `cmd_ready`/`cmd_get`/`cmd_data` handshake. It tags each command with its source for read-data routing.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `DEPTH`, 4: queue entries (power of 2, ≥2).
- `MAX_WAIT`, 8: row-hit bypass limit before forced round-robin (only with the macro).
- `ck`  in  1: clock; everything samples on posedge.
- `rst`  in  1: reset, asynchronous, active-high.
- `req_valid`  in  NREQ: requester i has a command.
- `req_data`  in  NREQ×65: per-requester command.
- `req_ready`  out  NREQ: one-hot grant; transfer when `req_valid[i] & req_ready[i]`.
- `cmd_ready`  out  1: queue non-empty (controller's "command available").
- `cmd_data`  out  65: queue head.
- `cmd_src`  out  $clog2(NREQ): requester index of head.
- `cmd_get`  in  1: controller fetch request (level; may be held several cycles).
- `fifo_level`  out  $clog2(DEPTH)+1: occupancy.

## Operation
- Grant is combinational from `req_valid`, `rr_ptr` and space. At most one `req_ready` bit is high per cycle. All bits are 0 when no space is available.
- Space exists when `count < DEPTH`, or when `count == DEPTH` and a pop occurs this cycle.
- Round-robin search starts at `rr_ptr` and wraps modulo NREQ. On a transfer from requester g, `rr_ptr <= (g+1) mod NREQ`. With no transfer, `rr_ptr` holds.
- Pop handshake:
  - Register `get_d <= cmd_get`.
  - A rising edge (`cmd_get & ~get_d`) with `count>0` sets `pop_pend`.
  - The pop executes on the next edge and clears `pop_pend`.
  - The head therefore stays stable for the cycle `cmd_get` is first seen high and the cycle after, which covers both controller sampling points.
  - Holding `cmd_get` high causes no further pops. A rising edge with `count==0` is ignored, not remembered.
- On each executed pop, record `open_bank = data[44:42]` (addr[12:10]), `open_row = data[60:45]` (addr[28:13]) and set `open_vld`.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- `cmd_data`/`cmd_src` are 0 while empty; this is a registered-path requirement, not X.
- Reset mid-operation: the queue empties, `rr_ptr=0`, `pop_pend=0`, `get_d=0`, `open_vld=0`. Commands in flight are dropped.
- Reset values: `req_ready=0`, `cmd_ready=0`, `cmd_data=0`, `cmd_src=0`, `fifo_level=0`.

## Timing
- A push on edge E makes `cmd_ready=1` and `fifo_level` increment visible after E. Push-to-head latency is 1 cycle when empty.
- Sequence: `cmd_get` sampled high at edge N (with `get_d=0`), pop at N+1, new head and `fifo_level` visible after N+1.
- Minimum spacing between pops is 2 cycles (edge detect plus `pop_pend`). Back-to-back controller fetches need `cmd_get` to drop for at least one cycle.
- Accept throughput is 1 command/cycle while not full.

## Configuration
- `DDR3_ARB_ROW_HIT_EN` defined:
  - Before round-robin, grant the lowest-index requester after `rr_ptr` whose address matches `open_bank`/`open_row` while `open_vld`.
  - Per-requester wait counters (saturating at `MAX_WAIT`) increment each cycle a valid requester is passed over. They clear on grant.
  - If any counter equals `MAX_WAIT`, the row-hit bypass is disabled and plain round-robin applies until that requester is granted.
  - A row-hit grant does not update `rr_ptr`.
- Undefined: pure round-robin. `open_*` tracking and wait counters are not built.

## Structure
- Package `ddr3_arb_pkg`:
  - `CMD_W=65`.
  - Field constants: `CMD_WR_BIT=64`, `ADDR_LSB=32`, `BANK_LSB=10`, `BANK_W=3`, `ROW_LSB=13`, `ROW_W=16` (address-relative).
  - Packed typedef `ddr3_cmd_t` {wr, addr[31:0], data[31:0]}.
  - Functions `bank_of`/`row_of`, shared with the controller's address mapping.
- Sub-module `ddr3_cmd_fifo`: synchronous DEPTH×(CMD_W+src) queue with push/pop/count, no bypass.

## Test plan
- Reset, then requester 2 pushes {wr=1, addr=0x0001_0200, data=0xDEADBEEF} → `cmd_ready=1` next cycle, `cmd_src=2`. `cmd_get` pulses 1 cycle → pop 2 cycles after assertion, `fifo_level=0`.
- All 4 requesters valid continuously, `cmd_get` toggling every 2 cycles → grant order 0,1,2,3,0…. The queue fills to 4, `req_ready` drops to 0 while full, and no entry is lost or duplicated.
- `cmd_get` held high 6 cycles with 3 entries queued → exactly one pop, `fifo_level` 3→2.
- Full queue; a push and a pop execute on the same edge → `fifo_level` stays 4 and order is preserved.
- Assert `rst` while `pop_pend=1` with 2 entries → all outputs 0 immediately (asynchronous), and no pop after release.
- With `DDR3_ARB_ROW_HIT_EN`:
  - Last popped addr 0x0001_0200. Req1 addr 0x0001_0204, req0 addr 0x0002_0000, `rr_ptr=0` → req1 granted first.
  - With req1 streaming hits, req0 is granted no later than cycle `MAX_WAIT`.
